// File: rtl/airlock_dock_controller_if.sv
// Dock request / status bundle between the request logic and the airlock controller.
interface airlock_dock_controller_if #(
    parameter int unsigned CNT_W = 3
) ();
    logic             arriving;
    logic             departing;
    logic [CNT_W-1:0] shipCount;
    logic             full;
    logic             empty;
    logic             outerDoor;
    logic             innerDoor;
    logic             busy;
    logic             reject;

    // Request side: raises arriving/departing, watches the status.
    modport master (
        output arriving,
        output departing,
        input  shipCount,
        input  full,
        input  empty,
        input  outerDoor,
        input  innerDoor,
        input  busy,
        input  reject
    );

    // Controller side.
    modport slave (
        input  arriving,
        input  departing,
        output shipCount,
        output full,
        output empty,
        output outerDoor,
        output innerDoor,
        output busy,
        output reject
    );
endinterface

// File: rtl/airlock_dock_controller.sv
// Multi-ship docking interlock: sequences a two-door airlock through timed
// pressure phases, tracks the docked ship count and flags refused requests.
module airlock_dock_controller #(
    parameter int unsigned CAPACITY     = 4,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned PRESS_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES  = 5
) (
    input logic                       clock,
    input logic                       reset,
    airlock_dock_controller_if.slave  dock
);
    localparam int unsigned MAX_CYC = (PRESS_CYCLES > DOOR_CYCLES) ? PRESS_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0]    PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0]    DOOR_LOAD  = TW'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_VAL    = CNT_W'(CAPACITY);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] DEPRESS    = 3'd1;
    localparam logic [2:0] OUTER_OPEN = 3'd2;
    localparam logic [2:0] REPRESS    = 3'd3;
    localparam logic [2:0] INNER_OPEN = 3'd4;

    // dir_q: 0 = arrival in progress, 1 = departure in progress
    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             reject_q, reject_d;

    logic full_w, empty_w, any_req, phase_done;

    assign full_w     = (count_q == CAP_VAL);
    assign empty_w    = (count_q == '0);
    assign any_req    = dock.arriving | dock.departing;
    assign phase_done = (timer_q == '0);

    // Next-state: request acceptance in IDLE, timed phase stepping otherwise.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        count_d  = count_q;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dock.departing && !empty_w) begin
                    // departure wins; a simultaneous arrival is refused
                    state_d  = INNER_OPEN;
                    timer_d  = DOOR_LOAD;
                    dir_d    = 1'b1;
                    reject_d = dock.arriving;
                end else if (dock.arriving && !full_w) begin
                    state_d = DEPRESS;
                    timer_d = PRESS_LOAD;
                    dir_d   = 1'b0;
                end else begin
                    reject_d = any_req;
                end
            end
            DEPRESS: begin
                reject_d = any_req;
                if (phase_done) begin
                    state_d = OUTER_OPEN;
                    timer_d = DOOR_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            OUTER_OPEN: begin
                reject_d = any_req;
                if (phase_done) begin
                    state_d = REPRESS;
                    timer_d = PRESS_LOAD;
                    // departing ship has left through the outer door
                    if (dir_q) begin
                        count_d = count_q - 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            REPRESS: begin
                reject_d = any_req;
                if (phase_done) begin
                    if (dir_q) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        state_d = INNER_OPEN;
                        timer_d = DOOR_LOAD;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            INNER_OPEN: begin
                reject_d = any_req;
                if (phase_done) begin
                    if (dir_q) begin
                        state_d = DEPRESS;
                        timer_d = PRESS_LOAD;
                    end else begin
                        // arriving ship is now inside the station
                        state_d = IDLE;
                        timer_d = '0;
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_q    <= 1'b0;
            count_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    // Outputs decoded from registered state only.
    assign dock.shipCount = count_q;
    assign dock.full      = full_w;
    assign dock.empty     = empty_w;
    assign dock.outerDoor = (state_q == OUTER_OPEN);
    assign dock.innerDoor = (state_q == INNER_OPEN);
    assign dock.busy      = (state_q != IDLE);
    assign dock.reject    = reject_q;
endmodule

// File: tb/tb_airlock_dock_controller.sv
// Randomised + directed bench for the airlock dock controller against a
// transfer-elapsed-time reference model.
module tb_airlock_dock_controller;
    localparam int CAP = 4;
    localparam int CW  = 3;
    localparam int P   = 8;
    localparam int D   = 5;
    localparam int T   = 2 * P + 2 * D;

    logic clock = 1'b0;
    logic reset;

    airlock_dock_controller_if #(.CNT_W(CW)) dock ();

    airlock_dock_controller #(
        .CAPACITY    (CAP),
        .CNT_W       (CW),
        .PRESS_CYCLES(P),
        .DOOR_CYCLES (D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dock (dock)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a transfer is "active" for T cycles; k counts edges since acceptance.
    int m_active = 0;
    int m_dir    = 0;
    int m_k      = 0;
    int m_cnt    = 0;
    int m_rej    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int arr, input int dep, input int rst);
        if (rst != 0) begin
            m_active = 0; m_k = 0; m_cnt = 0; m_rej = 0;
        end else if (m_active == 0) begin
            if (dep != 0 && m_cnt > 0) begin
                m_active = 1; m_dir = 1; m_k = 0; m_rej = arr;
            end else if (arr != 0 && m_cnt < CAP) begin
                m_active = 1; m_dir = 0; m_k = 0; m_rej = 0;
            end else begin
                m_rej = arr | dep;
            end
        end else begin
            m_rej = arr | dep;
            m_k++;
            if (m_dir == 1 && m_k == P + 2 * D) m_cnt--;
            if (m_k == T) begin
                m_active = 0;
                if (m_dir == 0) m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        int exp_outer;
        int exp_inner;
        exp_outer = 0;
        exp_inner = 0;
        if (m_active != 0) begin
            if (m_dir == 0) begin
                exp_outer = (m_k >= P && m_k < P + D) ? 1 : 0;
                exp_inner = (m_k >= 2 * P + D) ? 1 : 0;
            end else begin
                exp_inner = (m_k < D) ? 1 : 0;
                exp_outer = (m_k >= D + P && m_k < 2 * D + P) ? 1 : 0;
            end
        end
        check("busy",      32'(dock.busy),      32'(m_active));
        check("outerDoor", 32'(dock.outerDoor), 32'(exp_outer));
        check("innerDoor", 32'(dock.innerDoor), 32'(exp_inner));
        check("shipCount", 32'(dock.shipCount), 32'(m_cnt));
        check("full",      32'(dock.full),      32'(m_cnt == CAP));
        check("empty",     32'(dock.empty),     32'(m_cnt == 0));
        check("reject",    32'(dock.reject),    32'(m_rej));
        check("door_overlap", 32'(dock.outerDoor & dock.innerDoor), 32'd0);
        check("count_le_cap", 32'(dock.shipCount <= CW'(CAP)), 32'd1);
    endtask

    // One clock: drive inputs away from the edge, step model at the edge, check #1 after.
    task automatic cyc(input int arr, input int dep, input int rst);
        dock.arriving  = arr[0];
        dock.departing = dep[0];
        reset          = rst[0];
        @(posedge clock);
        model_edge(arr, dep, rst);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    initial begin
        dock.arriving  = 1'b0;
        dock.departing = 1'b0;
        reset          = 1'b1;
        @(negedge clock);

        // reset state
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        idle(2);

        // single arrival
        cyc(1, 0, 0);
        idle(T + 2);

        // fill to capacity, then one arrival too many
        for (int s = 0; s < 3; s++) begin
            cyc(1, 0, 0);
            idle(T + 1);
        end
        cyc(1, 0, 0);
        idle(3);

        // two departures down to 2, then simultaneous requests
        for (int s = 0; s < 2; s++) begin
            cyc(0, 1, 0);
            idle(T + 1);
        end
        cyc(1, 1, 0);
        idle(T + 2);

        // departing while empty
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        idle(2);

        // arrival, extra arrival mid-DEPRESS
        cyc(1, 0, 0);
        idle(3);
        cyc(1, 0, 0);
        idle(T + 2);

        // reset during OUTER_OPEN, then a normal arrival
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        idle(P + 2);
        cyc(0, 0, 1);
        idle(1);
        cyc(1, 0, 0);
        idle(T + 2);

        // held arrival across a whole cycle is re-accepted on first IDLE edge
        for (int i = 0; i < T + 4; i++) cyc(1, 0, 0);
        idle(T + 2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int a;
            int d;
            int r;
            a = ($urandom_range(0, 9) < 3) ? 1 : 0;
            d = ($urandom_range(0, 9) < 2) ? 1 : 0;
            r = ($urandom_range(0, 299) == 0) ? 1 : 0;
            cyc(a, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
